// File: rtl/mem_ctrl_pkg.sv
// Constants shared by the memory controller and the load/store side of the core:
// FSM encoding, access length codes, the memory-mapped IO address field and funct3 values.
package mem_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_IF_RD = 3'd1;
    localparam logic [2:0] ST_LS_RD = 3'd2;
    localparam logic [2:0] ST_LS_WR = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;

    // Addresses with bits 17:16 set reach the UART rather than RAM
    localparam logic [1:0] IO_ADDR_FIELD = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic is_io_addr(input logic [31:0] addr);
        return addr[17:16] == IO_ADDR_FIELD;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter: serves instruction fetches and load/store accesses one byte
// per cycle over a single-port RAM with one-cycle read latency.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int IF_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [31:0]           mem_a,
    output logic                  mem_wr,
    input  logic                  if_en,
    input  logic [31:0]           if_addr,
    output logic                  if_done,
    output logic [8*IF_LEN-1:0]   if_data,
    input  logic                  lsb_en,
    input  logic                  lsb_wr,
    input  logic [31:0]           lsb_addr,
    input  logic [2:0]            lsb_len,
    input  logic [31:0]           lsb_w_data,
    output logic                  lsb_done,
    output logic [31:0]           lsb_r_data
);

    localparam int         BUF_W     = 8 * IF_LEN;
    localparam logic [4:0] FETCH_LEN = 5'(IF_LEN);

    logic [2:0]       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [4:0]       len_q, len_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic             if_done_q, if_done_d;
    logic             lsb_done_q, lsb_done_d;
    logic [BUF_W-1:0] if_data_q, if_data_d;
    logic [31:0]      lsb_r_data_q, lsb_r_data_d;
    logic [7:0]       align_sh;
    logic [BUF_W-1:0] aligned;
    logic             stall;

    assign stall    = (state_q == ST_LS_WR) && is_io_addr(addr_q) && io_buffer_full;
    assign mem_a    = addr_q + {27'd0, cnt_q};
    assign mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    assign mem_wr   = rdy && (state_q == ST_LS_WR) && !stall;

    assign if_done    = if_done_q;
    assign if_data    = if_data_q;
    assign lsb_done   = lsb_done_q;
    assign lsb_r_data = lsb_r_data_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        if_done_d    = if_done_q;
        lsb_done_d   = lsb_done_q;
        if_data_d    = if_data_q;
        lsb_r_data_d = lsb_r_data_q;
        align_sh     = {FETCH_LEN - len_q, 3'b000};
        aligned      = '0;

        if (rdy) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = 5'd0;
                    buf_d = '0;
                    if (lsb_en) begin
                        addr_d  = lsb_addr;
                        len_d   = {2'b00, lsb_len};
                        wdata_d = lsb_w_data;
                        state_d = lsb_wr ? ST_LS_WR : ST_LS_RD;
                    end else if (if_en) begin
                        addr_d  = if_addr;
                        len_d   = FETCH_LEN;
                        state_d = ST_IF_RD;
                    end
                end
                ST_IF_RD, ST_LS_RD: begin
                    if (state_q == ST_IF_RD && rollback) begin
                        state_d = ST_IDLE;
                        cnt_d   = 5'd0;
                    end else begin
                        // RAM data lags the address by a cycle, so byte k-1 arrives while k is addressed
                        if (cnt_q != 5'd0) begin
                            buf_d = {mem_din, buf_q[BUF_W-1:8]};
                        end
                        if (cnt_q == len_q) begin
                            state_d = ST_DONE;
                            cnt_d   = 5'd0;
                            aligned = buf_d >> align_sh;
                            if (state_q == ST_IF_RD) begin
                                if_data_d = buf_d;
                                if_done_d = 1'b1;
                            end else begin
                                lsb_r_data_d = aligned[31:0];
                                lsb_done_d   = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                ST_LS_WR: begin
                    if (!stall) begin
                        if (cnt_q == len_q - 5'd1) begin
                            state_d    = ST_DONE;
                            cnt_d      = 5'd0;
                            lsb_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d    = ST_IDLE;
                    if_done_d  = 1'b0;
                    lsb_done_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 5'd0;
            len_q        <= 5'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            buf_q        <= '0;
            if_done_q    <= 1'b0;
            lsb_done_q   <= 1'b0;
            if_data_q    <= '0;
            lsb_r_data_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            if_done_q    <= if_done_d;
            lsb_done_q   <= lsb_done_d;
            if_data_q    <= if_data_d;
            lsb_r_data_q <= lsb_r_data_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected done pulses and RAM writes,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_en = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_en = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [31:0] lsb_addr = 32'd0;
    logic [2:0]  lsb_len = 3'd0;
    logic [31:0] lsb_w_data = 32'd0;
    logic        lsb_done;
    logic [31:0] lsb_r_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        bit          is_if;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    done_t dq[$];
    wr_t   wq[$];

    logic [7:0] ram [0:1023];

    mem_ctrl #(.IF_LEN(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .if_en(if_en), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data), .lsb_en(lsb_en), .lsb_wr(lsb_wr),
        .lsb_addr(lsb_addr), .lsb_len(lsb_len), .lsb_w_data(lsb_w_data),
        .lsb_done(lsb_done), .lsb_r_data(lsb_r_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        mem_din <= ram[mem_a[9:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse and every write strobe must match the head of its queue
    always @(negedge clk) begin
        done_t d;
        wr_t   w;
        if (if_done || lsb_done) begin
            if (dq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got if_done=%0b lsb_done=%0b expected none (cycle %0d)",
                         if_done, lsb_done, cyc);
            end else begin
                d = dq.pop_front();
                $display("done  if=%0b data=%h cycle=%0d", if_done, if_done ? if_data : lsb_r_data, cyc);
                chk("done_kind_if", {31'd0, if_done}, {31'd0, d.is_if});
                chk("done_kind_lsb", {31'd0, lsb_done}, {31'd0, !d.is_if});
                chk("done_cycle", cyc, d.cyc);
                if (d.chk_data) chk("done_data", d.is_if ? if_data : lsb_r_data, d.data);
            end
        end
        if (mem_wr) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h expected none (cycle %0d)",
                         mem_a, mem_dout, cyc);
            end else begin
                w = wq.pop_front();
                $display("write addr=%h data=%h cycle=%0d", mem_a, mem_dout, cyc);
                chk("wr_addr", mem_a, w.addr);
                chk("wr_data", {24'd0, mem_dout}, {24'd0, w.data});
                chk("wr_cycle", cyc, w.cyc);
            end
        end
    end

    task automatic check_zero(input string tag);
        $display("check %s outputs cleared (cycle %0d)", tag, cyc);
        chk({tag, "_mem_a"}, mem_a, 32'd0);
        chk({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
        chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({tag, "_if_done"}, {31'd0, if_done}, 32'd0);
        chk({tag, "_if_data"}, if_data, 32'd0);
        chk({tag, "_lsb_done"}, {31'd0, lsb_done}, 32'd0);
        chk({tag, "_lsb_r_data"}, lsb_r_data, 32'd0);
    endtask

    task automatic wait_done(input bit is_if);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = is_if ? if_done : lsb_done;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: got no %s pulse expected one within 40 cycles",
                     is_if ? "if_done" : "lsb_done");
        end
    endtask

    // Holds lsb_en until lsb_done, dropping it during the DONE cycle
    task automatic do_lsb(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                          input logic [31:0] wdata, input bit chk_data,
                          input logic [31:0] exp, input int lat);
        done_t d;
        @(posedge clk); #1;
        lsb_en = 1'b1; lsb_wr = wr; lsb_addr = addr; lsb_len = len; lsb_w_data = wdata;
        d.is_if = 0; d.chk_data = chk_data; d.data = exp; d.cyc = cyc + lat;
        dq.push_back(d);
        wait_done(0);
        lsb_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        done_t d;
        wr_t   w;
        int    t;

        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h040] = 8'h93; ram[10'h041] = 8'h85; ram[10'h042] = 8'hc5; ram[10'h043] = 8'h00;
        ram[10'h080] = 8'hEF; ram[10'h081] = 8'hBE; ram[10'h082] = 8'h7F;
        ram[10'h0C0] = 8'h5A;
        ram[10'h1A0] = 8'h01; ram[10'h1A1] = 8'h02; ram[10'h1A2] = 8'h03; ram[10'h1A3] = 8'h04;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Word load, done in T+6
        do_lsb(1'b0, 32'h100, 3'd4, 32'd0, 1, 32'h44332211, 6);

        // Byte store to the IO window while the UART buffer is full for three cycles
        fork
            do_lsb(1'b1, 32'h0003_0000, 3'd1, 32'h0000_00A5, 0, 32'd0, 5);
            begin
                @(posedge clk); #1;
                io_buffer_full = 1'b1;
                w.addr = 32'h0003_0000; w.data = 8'hA5; w.cyc = cyc + 4;
                wq.push_back(w);
                repeat (4) @(posedge clk);
                #1 io_buffer_full = 1'b0;
            end
        join

        // Simultaneous requests: load first, fetch granted in the IDLE after DONE
        @(posedge clk); #1;
        t = cyc;
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h1A0; lsb_len = 3'd4;
        if_en = 1'b1; if_addr = 32'h040;
        d.is_if = 0; d.chk_data = 1; d.data = 32'h04030201; d.cyc = t + 6;  dq.push_back(d);
        d.is_if = 1; d.chk_data = 1; d.data = 32'h00c58593; d.cyc = t + 13; dq.push_back(d);
        wait_done(0);
        lsb_en = 1'b0;
        wait_done(1);
        if_en = 1'b0;

        // Fetch aborted by rollback after byte 1; a following load is served normally
        @(posedge clk); #1;
        if_en = 1'b1; if_addr = 32'h140;
        @(posedge clk); #1;
        if_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rollback = 1'b1;
        @(posedge clk); #1;
        rollback = 1'b0;
        do_lsb(1'b0, 32'h0C0, 3'd1, 32'd0, 1, 32'h0000005A, 3);

        // Rollback during a halfword load does not disturb it
        fork
            do_lsb(1'b0, 32'h080, 3'd2, 32'd0, 1, 32'h0000BEEF, 4);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                rollback = 1'b1;
                @(posedge clk); #1;
                rollback = 1'b0;
            end
        join

        // Reset in the middle of a word store: byte 0 goes out, nothing else
        @(posedge clk); #1;
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h200; lsb_len = 3'd4; lsb_w_data = 32'h11223344;
        w.addr = 32'h200; w.data = 8'h44; w.cyc = cyc + 1;
        wq.push_back(w);
        @(posedge clk); #1;
        rst = 1'b1; lsb_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        repeat (8) @(posedge clk);
        @(negedge clk);

        chk("done_queue_empty", dq.size(), 0);
        chk("write_queue_empty", wq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
